// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and the default operand width.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_sign.sv
// Sign handling for muldiv_unit: operand magnitudes/sign flags on entry and
// the final negation of product, quotient and remainder on exit.
module muldiv_sign
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg_a,
    output logic               neg_b,
    input  logic               res_neg_a,
    input  logic               res_neg_b,
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   quot,
    input  logic [WIDTH-1:0]   rem,
    output logic [2*WIDTH-1:0] prod_fix,
    output logic [WIDTH-1:0]   quot_fix,
    output logic [WIDTH-1:0]   rem_fix
);

    always_comb begin
        neg_a    = op_is_signed(op) & a[WIDTH-1];
        neg_b    = op_is_signed(op) & b[WIDTH-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
        // Remainder follows the dividend; product and quotient follow the sign difference.
        prod_fix = (res_neg_a ^ res_neg_b) ? -prod : prod;
        quot_fix = (res_neg_a ^ res_neg_b) ? -quot : quot;
        rem_fix  = res_neg_a ? -rem : rem;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers;
// one iteration per cycle, WIDTH cycles per operation.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] RD1,
    input  logic [WIDTH-1:0] RD2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] WD,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);

    state_t               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic                 neg_a_q, neg_a_d, neg_b_q, neg_b_d;
    logic                 b_zero_q, b_zero_d;
    logic [WIDTH-1:0]     raw_a_q, raw_a_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic [WIDTH:0]       mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0]   iter_acc;
    logic [WIDTH-1:0]     iter_rem;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic                 neg_a, neg_b;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    muldiv_sign #(.WIDTH(WIDTH)) u_sign (
        .op        (op),
        .a         (RD1),
        .b         (RD2),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .neg_a     (neg_a),
        .neg_b     (neg_b),
        .res_neg_a (neg_a_q),
        .res_neg_b (neg_b_q),
        .prod      (iter_acc),
        .quot      (iter_acc[WIDTH-1:0]),
        .rem       (iter_rem),
        .prod_fix  (prod_fix),
        .quot_fix  (quot_fix),
        .rem_fix   (rem_fix)
    );

    // Multiply: acc = {partial, multiplier}; divide: acc[WIDTH-1:0] holds dividend->quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem_q, acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (op_is_div(op_q)) begin
            iter_acc = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            iter_rem = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        end else begin
            iter_acc = {mul_sum, acc_q[WIDTH-1:1]};
            iter_rem = rem_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        b_zero_d = b_zero_q;
        raw_a_d  = raw_a_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    op_d     = op;
                    neg_a_d  = neg_a;
                    neg_b_d  = neg_b;
                    raw_a_d  = RD1;
                    b_zero_d = (RD2 == '0);
                    opnd_d   = op_is_div(op) ? mag_b : mag_a;
                    acc_d    = {{WIDTH{1'b0}}, (op_is_div(op) ? mag_a : mag_b)};
                    rem_d    = '0;
                end else begin
                    if (hi_we) hi_d = WD;
                    if (lo_we) lo_d = WD;
                end
            end
            RUN: begin
                acc_d = iter_acc;
                rem_d = iter_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    if (!op_is_div(op_q)) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (b_zero_q) begin
                        hi_d = raw_a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            raw_a_q  <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            b_zero_q <= b_zero_d;
            raw_a_q  <= raw_a_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
